// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit period and the FSM state encoding
// used by both the receiver and the transmitter on the same link.
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_CLK_PER_BIT = 4;
    localparam int UART_CNT_W       = 16;
    localparam int UART_IDX_W       = $clog2(UART_DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both stages reset to RST_VAL.
// Latency 2 clk; no flow control.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; byte/frame-error strobes one cycle after the stop sample.
// Latency: HALF+9*CLK_PER_BIT+1 clk from the synchronised start edge; no backpressure (unread bytes are overwritten).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam logic [UART_CNT_W-1:0] HALF_M1 = UART_CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [UART_CNT_W-1:0] BIT_M1  = UART_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [UART_IDX_W-1:0] LAST_IX = UART_IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_state_t               state_q, state_d;
    logic [UART_CNT_W-1:0]     count_q, count_d;
    logic [UART_IDX_W-1:0]     index_q, index_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q,  data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q,  ferr_d;
    logic                      armed_q, armed_d;
    logic [1:0]                settle_q, settle_d;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        index_d  = index_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        // The synchroniser's reset value of 1 is not a real line observation, so arming
        // waits until both stages have been refilled from rx.
        settle_d = {settle_q[0], 1'b1};
        armed_d  = armed_q | (settle_q[1] & rx_s);

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                index_d = '0;
                if (armed_q && !rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (count_q == HALF_M1) begin
                    count_d = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (count_q == BIT_M1) begin
                    count_d          = '0;
                    shift_d[index_q] = rx_s;
                    if (index_q == LAST_IX) begin
                        state_d = ST_STOP;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (count_q == BIT_M1) begin
                    count_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_RECOVER;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            // A held-low or break line parks here so it reports a single frame error.
            ST_RECOVER: begin
                count_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            index_q  <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            index_q  <= index_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx (CLK_PER_BIT=4): directed frames, a frame-level timing model checked every
// cycle, plus literal checks on latency, data, pulse counts, reset and arming behaviour.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int N    = 4;
    localparam int HALF = N / 2;
    // rx driven in cycle m reaches the FSM at edge m+3 (two sync flops, then the state register).
    localparam int SYNC = 3;
    localparam int EVT  = SYNC + HALF + 9 * N;
    localparam int MAXC = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLK_PER_BIT (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- frame-level model: expected outputs per cycle ----------------
    bit         exp_v  [MAXC];
    bit         exp_fe [MAXC];
    bit         exp_bz [MAXC];
    logic [7:0] exp_d  [MAXC];
    logic [7:0] mdl_byte = 8'h00;
    bit         chk_en = 1'b0;

    function automatic void mdl_frame(input int m, input logic [7:0] b, input bit stop_ok);
        for (int k = m + SYNC; k < m + EVT; k++) exp_bz[k] = 1'b1;
        if (stop_ok) begin
            exp_v[m + EVT] = 1'b1;
            exp_d[m + EVT] = b;
        end else begin
            exp_fe[m + EVT] = 1'b1;
        end
    endfunction

    // Line returns high in cycle h: busy lasts until the FSM sees it.
    function automatic void mdl_recover(input int m, input int h);
        for (int k = m + EVT; k < h + SYNC; k++) exp_bz[k] = 1'b1;
    endfunction

    function automatic void mdl_glitch(input int m);
        for (int k = m + SYNC; k < m + SYNC + HALF; k++) exp_bz[k] = 1'b1;
    endfunction

    function automatic void mdl_reset(input int from);
        for (int k = from; k < MAXC; k++) begin
            exp_v[k]  = 1'b0;
            exp_fe[k] = 1'b0;
            exp_bz[k] = 1'b0;
        end
        mdl_byte = 8'h00;
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            if (exp_v[cyc]) mdl_byte = exp_d[cyc];
            check("valid",     {31'd0, valid},     {31'd0, exp_v[cyc]});
            check("frame_err", {31'd0, frame_err}, {31'd0, exp_fe[cyc]});
            check("busy",      {31'd0, busy},      {31'd0, exp_bz[cyc]});
            check("data_out",  {24'd0, data_out},  {24'd0, mdl_byte});
        end
    end

    // ---------------- event monitor for literal checks ----------------
    logic [7:0] got[$];
    int vcnt = 0;
    int fecnt = 0;
    int bcnt = 0;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            got.push_back(data_out);
        end
        if (frame_err) fecnt++;
        if (busy) bcnt++;
    end

    task automatic clear_mon();
        got.delete();
        vcnt  = 0;
        fecnt = 0;
        bcnt  = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx = 1'b1;
        end
    endtask

    // Transmitter model: one 10-bit frame; interior edges shifted by +jit/-jit alternately.
    task automatic tx_send(input logic [7:0] b, input bit stop, input int jit, output int m);
        logic [9:0] bits;
        int idx;
        bits = {stop, b, 1'b0};
        m = 0;
        for (int t = 0; t < 10 * N; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                m = cyc;
                mdl_frame(m, b, stop);
            end
            idx = 0;
            for (int k = 1; k < 10; k++) begin
                if (t >= k * N + ((k % 2 == 1) ? jit : -jit)) idx = k;
            end
            rx = bits[idx];
        end
    endtask

    task automatic wait_evt(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid || frame_err) begin
                at = cyc;
                break;
            end
        end
        tests++;
        if (at < 0) begin
            fails++;
            $display("FAIL evt_timeout: got no event within %0d cycles, expected one", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected bench end");
        $fatal(1);
    end

    initial begin
        int m;
        int at;

        // ---- reset ----
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",  {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, valid},    32'h0);
        check("rst_ferr",  {31'd0, frame_err}, 32'h0);
        check("rst_busy",  {31'd0, busy},     32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        idle(6);

        // ---- single byte ----
        clear_mon();
        tx_send(8'hA5, 1'b1, 0, m);
        wait_evt(10, at);
        check("a5_latency", at - m, 32'd41);
        check("a5_data",   {24'd0, data_out}, 32'hA5);
        check("a5_ferr",   {31'd0, frame_err}, 32'h0);
        check("a5_busy",   {31'd0, busy},     32'h0);
        @(negedge clk);
        check("a5_valid_1cyc", {31'd0, valid}, 32'h0);
        idle(4);

        // ---- back-to-back loopback frames ----
        clear_mon();
        tx_send(8'h00, 1'b1, 0, m);
        tx_send(8'hFF, 1'b1, 0, m);
        tx_send(8'h3C, 1'b1, 0, m);
        idle(6);
        check("lb_count", vcnt, 32'd3);
        if (got.size() == 3) begin
            check("lb_b0", {24'd0, got[0]}, 32'h00);
            check("lb_b1", {24'd0, got[1]}, 32'hFF);
            check("lb_b2", {24'd0, got[2]}, 32'h3C);
        end
        check("lb_ferr", fecnt, 32'd0);

        // ---- single-cycle glitch ----
        clear_mon();
        @(posedge clk); #1;
        mdl_glitch(cyc);
        rx = 1'b0;
        idle(15);
        check("gl_busy_cycles", bcnt, 32'd2);
        check("gl_valid", vcnt, 32'd0);
        check("gl_ferr",  fecnt, 32'd0);

        // ---- framing error, then line held low ----
        clear_mon();
        tx_send(8'h5A, 1'b0, 0, m);
        mdl_recover(m, m + 80);
        repeat (40) begin
            @(posedge clk); #1;
            rx = 1'b0;
        end
        check("fe_count_low", fecnt, 32'd1);
        check("fe_busy_held", {31'd0, busy}, 32'h1);
        idle(15);
        check("fe_count", fecnt, 32'd1);
        check("fe_valid", vcnt, 32'd0);
        check("fe_data_kept", {24'd0, data_out}, 32'h3C);

        // ---- reset during data bit 3 with the line held low ----
        @(posedge clk); #1;
        m = cyc;
        mdl_frame(m, 8'h00, 1'b1);
        rx = 1'b0;
        repeat (16) begin
            @(posedge clk); #1;
            rx = 1'b0;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        mdl_reset(cyc);
        #1;
        check("mr_data",  {24'd0, data_out}, 32'h00);
        check("mr_valid", {31'd0, valid},    32'h0);
        check("mr_ferr",  {31'd0, frame_err}, 32'h0);
        check("mr_busy",  {31'd0, busy},     32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        clear_mon();
        repeat (20) begin
            @(posedge clk); #1;
            rx = 1'b0;
        end
        check("mr_unarmed_busy", bcnt, 32'd0);
        idle(6);
        tx_send(8'h81, 1'b1, 0, m);
        idle(6);
        check("mr_count", vcnt, 32'd1);
        if (got.size() == 1) check("mr_byte", {24'd0, got[0]}, 32'h81);

        // ---- sample alignment with edges moved by +/-1 clock ----
        clear_mon();
        tx_send(8'h55, 1'b1,  1, m);
        tx_send(8'h55, 1'b1, -1, m);
        idle(6);
        check("al_count", vcnt, 32'd2);
        if (got.size() == 2) begin
            check("al_late",  {24'd0, got[0]}, 32'h55);
            check("al_early", {24'd0, got[1]}, 32'h55);
        end
        check("al_ferr", fecnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
